// File: rtl/uart_pkg.sv
// Shared definitions for the second-generation UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  function automatic int cnt_w(input int clks);
    return $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX synchroniser, bit-period counter and sample strobe generation.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around each sample point.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic run,
  input  logic half,
  output logic rx_sync,
  output logic sample_stb,
  output logic sample_bit
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] TGT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TGT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tgt;
  logic          hit;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};

  assign rx_sync = sync[1];
  assign tgt     = half ? TGT_HALF : TGT_FULL;
  assign hit     = run && (cnt == tgt);

  // Counter idles at 0 so START always begins from a clean period.
  always_ff @(posedge clk or posedge rst)
    if (rst)              cnt <= '0;
    else if (!run || hit) cnt <= '0;
    else                  cnt <= cnt + 1'b1;

`ifdef UART_RX_MAJORITY_EN
  logic [CW-1:0] tgt_m1;
  logic          v0, v1, pend;

  assign tgt_m1 = tgt - 1'b1;

  // The vote closes one cycle after the target using the live synchronised bit.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v0   <= 1'b0;
      v1   <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= hit;
      if (run && cnt == tgt_m1) v0 <= rx_sync;
      if (hit)                  v1 <= rx_sync;
    end

  assign sample_stb = pend;
  assign sample_bit = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
`else
  assign sample_stb = hit;
  assign sample_bit = rx_sync;
`endif

endmodule

// File: rtl/uart_rx_gen2.sv
// Oversampled UART receiver with parity/framing/break/overrun reporting and a
// one-entry valid/ready output register. Optional macro: UART_RX_MAJORITY_EN.
module uart_rx_gen2
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 pen,
  input  logic                 peven,
  output logic                 busy,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 perr,
  output logic                 ferr,
  output logic                 brk,
  output logic                 ovr
);

  uart_rx_state_t       state;
  logic [DATA_BITS-1:0] sh;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 pen_l, peven_l, par_bit, ferr_acc;
  logic                 rx_sync, stb, sbit;
  logic                 last_stop, fin, accept;
  logic                 perr_n, ferr_n, brk_n;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_smp (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .run        (busy),
    .half       (state == ST_START),
    .rx_sync    (rx_sync),
    .sample_stb (stb),
    .sample_bit (sbit)
  );

  always_comb begin
    last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
    fin       = (state == ST_STOP) && stb && last_stop;
    accept    = !valid || ready;
    ferr_n    = ferr_acc | ~sbit;
    perr_n    = pen_l & (^sh ^ par_bit ^ (peven_l == PAR_ODD));
    // par_bit stays 0 without parity, so it only vetoes break when a 1 was seen.
    brk_n     = ~(|sh) & ~par_bit & ferr_n;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      sh       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      pen_l    <= 1'b0;
      peven_l  <= 1'b0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      dout     <= '0;
      valid    <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      brk      <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      case (state)
        ST_IDLE:
          if (!rx_sync) begin
            state   <= ST_START;
            busy    <= 1'b1;
            pen_l   <= pen;
            peven_l <= peven;
          end
        ST_START:
          if (stb) begin
            if (sbit) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
        ST_DATA:
          if (stb) begin
            sh <= {sbit, sh[DATA_BITS-1:1]};
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              ferr_acc <= 1'b0;
              par_bit  <= 1'b0;
              state    <= pen_l ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        ST_PARITY:
          if (stb) begin
            par_bit <= sbit;
            state   <= ST_STOP;
          end
        ST_STOP:
          if (stb) begin
            if (last_stop) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
              ferr_acc <= ferr_n;
            end
          end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A completing frame overrides the valid clear above when it is accepted.
      if (fin) begin
        if (accept) begin
          dout  <= sh;
          perr  <= perr_n;
          ferr  <= ferr_n;
          brk   <= brk_n;
          valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end
    end

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Scoreboard bench for uart_rx_gen2: directed scenarios plus random frames.
module tb_uart_rx_gen2;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SB  = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, rx, pen, peven, ready;
  logic          busy, valid, perr, ferr, brk, ovr;
  logic [DB-1:0] dout;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ovr_cycles = 0;
  exp_t q[$];

  uart_rx_gen2 #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .pen   (pen),
    .peven (peven),
    .busy  (busy),
    .dout  (dout),
    .valid (valid),
    .ready (ready),
    .perr  (perr),
    .ferr  (ferr),
    .brk   (brk),
    .ovr   (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic p_en, input logic p_even,
                                 input logic pbit, input logic s1, input logic s2);
    exp_t e;
    int   ones;
    ones   = $countones(d) + int'(pbit);
    e.d    = d;
    e.perr = p_en && (p_even ? (ones % 2 == 1) : (ones % 2 == 0));
    e.ferr = !(s1 && s2);
    e.brk  = (d == 8'h00) && (!p_en || !pbit) && e.ferr;
    return e;
  endfunction

  // Monitor: a frame is consumed on the edge following valid && ready.
  always @(negedge clk) begin
    if (ovr === 1'b1) ovr_cycles++;
    if (!rst && valid && ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got %0h expected none", dout);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("frame", {21'd0, dout, perr, ferr, brk}, {21'd0, e});
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p_en, input logic p_even,
                            input logic pbit, input logic s1, input logic s2, input bit push);
    @(posedge clk);
    #1;
    pen   = p_en;
    peven = p_even;
    if (push) q.push_back(model(d, p_en, p_even, pbit, s1, s2));
    send_bit(1'b0);
    pen   = 1'($urandom);
    peven = 1'($urandom);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (p_en) send_bit(pbit);
    send_bit(s1);
    send_bit(s2);
    rx = 1'b1;
    if (!s2) repeat (40) @(posedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    check("drain", q.size(), 0);
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_flags"}, {perr, ferr, brk, ovr}, 0);
    check({tag, "_dout"},  dout,  0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; pen = 1'b0; peven = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Held frame, then one-cycle ready consumes it.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    check("held_valid", valid, 1);
    check("held_dout", dout, 8'hA5);
    pulse_ready();
    check("valid_cleared", valid, 0);

    ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    wait_drain();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    wait_drain();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    wait_drain();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    wait_drain();

    // Short low glitch on idle line.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    check("glitch_busy_hi", busy, 1);
    repeat (40) @(posedge clk);
    #1;
    check("glitch_busy_lo", busy, 0);
    check("glitch_valid", valid, 0);

    // Overrun: second frame dropped while the first is held.
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check("ovr_valid", valid, 1);
    check("ovr_dout", dout, 8'h11);
    check("ovr_pulse", ovr_cycles, 1);
    pulse_ready();
    wait_drain();

    // Reset in the middle of data bit 4 while a frame is held.
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("pre_rst_valid", valid, 1);
    @(posedge clk);
    #1 send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    rx = 1'b1;
    q.delete();
    #20 rst = 1'b0;
    ready = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    wait_drain();

    // Random frames with random parity/stop errors.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       pe, pv, pb, s1, s2;
      d  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pe = 1'($urandom);
      pv = 1'($urandom);
      pb = 1'($urandom);
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      send_frame(d, pe, pv, pb, s1, s2, 1);
      repeat ($urandom_range(0, 10)) @(posedge clk);
      wait_drain();
    end

    check("ovr_total", ovr_cycles, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
